// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions: opcodes, fetch-state encoding, reset vector
// and the common 16-bit adder used for PC arithmetic.
package fetch_unit_pkg;

  localparam logic [15:0] DEF_RESET_PC   = 16'h0000;
  localparam logic [3:0]  DEF_HLT_OPCODE = 4'hF;
  localparam logic [15:0] NOOP_WORD      = 16'h0000;
  localparam logic [15:0] PC_STEP        = 16'h0002;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2,
    HALT   = 2'd3
  } fetch_state_e;

  function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// 16-bit program counter: load has priority over increment-by-2, else hold.
module pc_register
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        inc_i,
  input  logic [15:0] load_val_i,
  output logic [15:0] pc_o
);

  logic [15:0] pc_q;
  logic [15:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = add16(pc_q, PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the variable-latency I-memory
// request handshake and loads the IF/ID register.
//
// state  | meaning
// FETCH  | request at PC; deliver, bubble, redirect or capture on stall
// HOLD   | word returned during a stall sits in the hold buffer
// SQUASH | redirect arrived mid-miss; finish old request and discard it
// HALT   | HLT reached IF/ID; fetch frozen until redirect or reset
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [3:0]  HLT_OPCODE = DEF_HLT_OPCODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_Stall,
  input  logic        IF_PCDisrupt,
  input  logic [15:0] IF_PCBranch,
  input  logic        IMem_Ready,
  input  logic [15:0] IMem_Data,
  output logic        IMem_Req,
  output logic [15:0] IMem_Addr,
  output logic [15:0] IFID_Instruction,
  output logic [15:0] IFID_PC,
  output logic        IFID_Valid,
  output logic        Halted
);

  fetch_state_e state_q, state_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  ifid_pc_q, ifid_pc_d;
  logic         valid_q, valid_d;
  logic [15:0]  hbuf_q, hbuf_d;
  logic [15:0]  sq_addr_q, sq_addr_d;

  logic         pc_load;
  logic         pc_inc;
  logic [15:0]  pc;
  logic         do_deliver;
  logic [15:0]  deliver_word;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load),
    .inc_i      (pc_inc),
    .load_val_i (IF_PCBranch),
    .pc_o       (pc)
  );

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    ifid_pc_d    = ifid_pc_q;
    valid_d      = valid_q;
    hbuf_d       = hbuf_q;
    sq_addr_d    = sq_addr_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    do_deliver   = 1'b0;
    deliver_word = NOOP_WORD;

    unique case (state_q)
      FETCH: begin
        if (IF_PCDisrupt) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          if (!IMem_Ready) begin
            state_d   = SQUASH;
            sq_addr_d = pc;
          end
        end else if (IF_Stall) begin
          if (IMem_Ready) begin
            hbuf_d  = IMem_Data;
            state_d = HOLD;
          end
        end else if (IMem_Ready) begin
          do_deliver   = 1'b1;
          deliver_word = IMem_Data;
        end else begin
          valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (IF_PCDisrupt) begin
          pc_load = 1'b1;
          hbuf_d  = NOOP_WORD;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!IF_Stall) begin
          do_deliver   = 1'b1;
          deliver_word = hbuf_q;
          state_d      = FETCH;
        end
      end

      SQUASH: begin
        if (IF_PCDisrupt) begin
          pc_load = 1'b1;
        end
        if (!IF_Stall) begin
          valid_d = 1'b0;
        end
        if (IMem_Ready) begin
          state_d = FETCH;
        end
      end

      HALT: begin
        if (IF_PCDisrupt) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase

    // HLT leaves the PC on its own address so a redirect-free halt is inspectable.
    if (do_deliver) begin
      instr_d   = deliver_word;
      ifid_pc_d = pc;
      valid_d   = 1'b1;
      if (deliver_word[15:12] == HLT_OPCODE) begin
        state_d = HALT;
      end else begin
        pc_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      instr_q   <= NOOP_WORD;
      ifid_pc_q <= 16'h0000;
      valid_q   <= 1'b0;
      hbuf_q    <= NOOP_WORD;
      sq_addr_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
      hbuf_q    <= hbuf_d;
      sq_addr_q <= sq_addr_d;
    end
  end

  assign IMem_Req         = !rst && ((state_q == FETCH) || (state_q == SQUASH));
  assign IMem_Addr        = (state_q == SQUASH) ? sq_addr_q : pc;
  assign IFID_Instruction = instr_q;
  assign IFID_PC          = ifid_pc_q;
  assign IFID_Valid       = valid_q;
  assign Halted           = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hits, HLT, miss, redirect-during-miss,
// stall hold buffer, stall+redirect, PC wrap and reset mid-miss.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        IF_Stall;
  logic        IF_PCDisrupt;
  logic [15:0] IF_PCBranch;
  logic        IMem_Ready;
  logic [15:0] IMem_Data;
  logic        IMem_Req;
  logic [15:0] IMem_Addr;
  logic [15:0] IFID_Instruction;
  logic [15:0] IFID_PC;
  logic        IFID_Valid;
  logic        Halted;

  logic        tie;
  logic        rdy_drv;
  logic [15:0] mem [256];

  int err_cnt = 0;
  int chk_cnt = 0;

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .IF_Stall         (IF_Stall),
    .IF_PCDisrupt     (IF_PCDisrupt),
    .IF_PCBranch      (IF_PCBranch),
    .IMem_Ready       (IMem_Ready),
    .IMem_Data        (IMem_Data),
    .IMem_Req         (IMem_Req),
    .IMem_Addr        (IMem_Addr),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PC          (IFID_PC),
    .IFID_Valid       (IFID_Valid),
    .Halted           (Halted)
  );

  // tie=1 models a zero-wait memory that answers every request it sees
  assign IMem_Ready = tie ? IMem_Req : rdy_drv;
  assign IMem_Data  = mem[IMem_Addr[8:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic s, input logic d, input logic [15:0] br,
                     input logic t, input logic r);
    IF_Stall     = s;
    IF_PCDisrupt = d;
    IF_PCBranch  = br;
    tie          = t;
    rdy_drv      = r;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i << 1);
    mem[3]    = 16'hF006;
    mem[8'h21] = 16'hA123;

    rst = 1'b1;
    drv(0, 0, 16'h0000, 0, 0);
    tick();
    tick();
    chk("rst_req", {15'd0, IMem_Req}, 16'd0);
    chk("rst_valid", {15'd0, IFID_Valid}, 16'd0);
    chk("rst_instr", IFID_Instruction, 16'h0000);
    chk("rst_ifidpc", IFID_PC, 16'h0000);
    chk("rst_halted", {15'd0, Halted}, 16'd0);

    // zero-wait stream up to HLT at 0x0006
    rst = 1'b0;
    drv(0, 0, 16'h0000, 1, 0);
    chk("hit_addr0", IMem_Addr, 16'h0000);
    chk("hit_req0", {15'd0, IMem_Req}, 16'd1);
    tick();
    chk("hit_pc0", IFID_PC, 16'h0000);
    chk("hit_instr0", IFID_Instruction, 16'h1000);
    chk("hit_valid0", {15'd0, IFID_Valid}, 16'd1);
    chk("hit_addr2", IMem_Addr, 16'h0002);
    tick();
    chk("hit_pc2", IFID_PC, 16'h0002);
    chk("hit_addr4", IMem_Addr, 16'h0004);
    tick();
    chk("hit_pc4", IFID_PC, 16'h0004);
    chk("hit_addr6", IMem_Addr, 16'h0006);
    tick();
    chk("hlt_instr", IFID_Instruction, 16'hF006);
    chk("hlt_pc", IFID_PC, 16'h0006);
    chk("hlt_halted", {15'd0, Halted}, 16'd1);
    chk("hlt_req", {15'd0, IMem_Req}, 16'd0);
    chk("hlt_addr", IMem_Addr, 16'h0006);
    tick();
    chk("hlt_stay", {15'd0, Halted}, 16'd1);
    chk("hlt_hold_instr", IFID_Instruction, 16'hF006);

    // wrong-path HLT: redirect out of HALT
    drv(0, 1, 16'h0020, 1, 0);
    tick();
    chk("unhalt_halted", {15'd0, Halted}, 16'd0);
    chk("unhalt_valid", {15'd0, IFID_Valid}, 16'd0);
    chk("unhalt_addr", IMem_Addr, 16'h0020);
    drv(0, 0, 16'h0000, 1, 0);
    tick();
    chk("unhalt_pc", IFID_PC, 16'h0020);
    chk("unhalt_instr", IFID_Instruction, 16'h1020);

    // miss at 0x0010, ready on the 4th cycle
    drv(0, 1, 16'h0010, 1, 0);
    tick();
    drv(0, 0, 16'h0000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("miss_addr", IMem_Addr, 16'h0010);
      tick();
      chk("miss_bubble", {15'd0, IFID_Valid}, 16'd0);
    end
    chk("miss_addr_last", IMem_Addr, 16'h0010);
    drv(0, 0, 16'h0000, 0, 1);
    tick();
    chk("miss_ifidpc", IFID_PC, 16'h0010);
    chk("miss_valid", {15'd0, IFID_Valid}, 16'd1);
    chk("miss_next_addr", IMem_Addr, 16'h0012);

    // redirect to 0x0040 during a miss at 0x0010
    drv(0, 1, 16'h0010, 1, 0);
    tick();
    drv(0, 0, 16'h0000, 0, 0);
    tick();
    drv(0, 1, 16'h0040, 0, 0);
    tick();
    chk("sq_addr", IMem_Addr, 16'h0010);
    chk("sq_req", {15'd0, IMem_Req}, 16'd1);
    chk("sq_valid", {15'd0, IFID_Valid}, 16'd0);
    drv(0, 0, 16'h0000, 0, 0);
    tick();
    chk("sq_addr_hold", IMem_Addr, 16'h0010);
    drv(0, 0, 16'h0000, 0, 1);
    tick();
    chk("sq_drop_valid", {15'd0, IFID_Valid}, 16'd0);
    chk("sq_new_addr", IMem_Addr, 16'h0040);
    drv(0, 0, 16'h0000, 1, 0);
    tick();
    chk("sq_tgt_pc", IFID_PC, 16'h0040);
    chk("sq_tgt_instr", IFID_Instruction, 16'h1040);

    // stall for 3 cycles while a hit returns 0xA123 from 0x0042
    drv(1, 0, 16'h0000, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req", {15'd0, IMem_Req}, 16'd0);
      chk("stall_ifidpc", IFID_PC, 16'h0040);
      chk("stall_instr", IFID_Instruction, 16'h1040);
    end
    drv(0, 0, 16'h0000, 1, 0);
    tick();
    chk("unstall_instr", IFID_Instruction, 16'hA123);
    chk("unstall_pc", IFID_PC, 16'h0042);
    chk("unstall_valid", {15'd0, IFID_Valid}, 16'd1);
    chk("unstall_addr", IMem_Addr, 16'h0044);

    // stall and redirect together
    drv(1, 1, 16'h0100, 1, 0);
    tick();
    chk("sd_valid", {15'd0, IFID_Valid}, 16'd0);
    chk("sd_addr", IMem_Addr, 16'h0100);
    drv(0, 0, 16'h0000, 1, 0);
    tick();
    chk("sd_pc", IFID_PC, 16'h0100);
    chk("sd_instr", IFID_Instruction, 16'h1100);

    // PC wrap FFFE -> 0000
    drv(0, 1, 16'hFFFE, 1, 0);
    tick();
    chk("wrap_addr", IMem_Addr, 16'hFFFE);
    drv(0, 0, 16'h0000, 1, 0);
    tick();
    chk("wrap_ifidpc", IFID_PC, 16'hFFFE);
    chk("wrap_instr", IFID_Instruction, 16'h11FE);
    chk("wrap_next", IMem_Addr, 16'h0000);

    // reset during a miss at 0x0030
    drv(0, 1, 16'h0030, 1, 0);
    tick();
    drv(0, 0, 16'h0000, 0, 0);
    tick();
    chk("rm_addr", IMem_Addr, 16'h0030);
    rst = 1'b1;
    #1;
    chk("rm_req_in_rst", {15'd0, IMem_Req}, 16'd0);
    tick();
    chk("rm_req_after", {15'd0, IMem_Req}, 16'd0);
    chk("rm_valid", {15'd0, IFID_Valid}, 16'd0);
    rst = 1'b0;
    #1;
    chk("rm_pc", IMem_Addr, 16'h0000);
    chk("rm_req_resume", {15'd0, IMem_Req}, 16'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
